prefix_adder_pipe: RTL and testbench
====================================

Name: prefix_adder_pipe

Overview:
- Pipelined 32-bit parallel-prefix (Kogge-Stone) adder/subtractor for the FPU mantissa and exponent datapath.
- Input stage generates per-bit generate/propagate terms and feeds five prefix-combine levels with spans 1, 2, 4, 8 and 16.
- Output stage forms the sum, carry-out and flags.
- Pipeline registers sit after selectable prefix levels; valid/ready handshakes on both sides give full throughput with backpressure.

Parameters:
- REG_MASK, 5'b00100: bit k=1 places a pipeline register after prefix level k+1 (span 1<<k).
- WIDTH, 32: operand width. Fixed at 32; any other value is a parameter error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  32  operand A.
- b  input  32  operand B.
- cin  input  1  carry-in.
- sub  input  1  1 = A - B: B is inverted and the effective carry-in is forced to 1; cin is ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  32  A+B+cin, or A-B, modulo 2^32.
- cout  output  1  carry out of bit 31. For sub, 1 means no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (async assert, sync release): every stage valid bit = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
  - in_ready = 1 during and after reset.
  - Reset mid-operation discards all in-flight beats; no output is produced for them.
- Stage S0 (input register), captured on in_valid & in_ready:
  - bb = sub ? ~b : b; c0 = sub ? 1 : cin.
  - p[i] = a[i]^bb[i]; g[i] = a[i]&bb[i]. Bit 0 absorbs carry-in: g[0] = a0&bb0 | p0&c0.
  - S0 stores hp = p (half-sum), c0, a[31], bb[31], plus the initial G/P vectors.
- Prefix level k (k = 1..5, d = 1<<(k-1)):
  - Bits i < d pass G/P through unchanged.
  - Bits i >= d: G[i] = G[i] | (P[i] & G[i-d]); P[i] = P[i] & P[i-d].
  - hp, c0 and the sign bits travel alongside.
- Output stage (always registered):
  - carry into bit i: c[0] = c0, c[i] = G[i-1].
  - sum = hp ^ c; cout = G[31]; ovf = c[31] ^ cout; zero = (sum == 0).
- Latency from accept to out_valid = 2 + popcount(REG_MASK). Default = 3 cycles.
- Pipeline control, per registered stage j holding valid v[j]:
  - adv[j] = v[j] & (next stage empty | adv[next]). For the last stage, adv = out_valid & out_ready.
  - A stage loads when its upstream advances. It clears when it advances and no new beat arrives.
  - in_ready = ~v[S0] | adv[S0]. This is combinational from out_ready through the chain; there is no in_valid -> in_ready path.
- Stall: stage data holds stable while out_valid & ~out_ready. sum, cout, ovf and zero must not change while out_valid=1 and out_ready=0.
- Throughput: one beat per cycle when out_ready is held 1. Occupancy never exceeds the number of registered stages; no beat is dropped or duplicated.
- Simultaneous events:
  - Accept and drain in the same cycle on a full pipe is legal and keeps the pipe full.
  - in_valid while in_ready=0: inputs are ignored, and the source must hold them.
- Boundaries: no special-casing.
  - 0xFFFFFFFF+1 wraps to 0 with cout=1, zero=1.
  - 0x7FFFFFFF+1 sets ovf=1.
  - sub with a==b gives zero=1, cout=1.

Test Plan:
- Reset, then a=0x0000_0001, b=0x0000_0002, cin=1, sub=0, out_ready=1 -> out_valid exactly 3 cycles after accept; sum=0x0000_0004, cout=0, ovf=0, zero=0.
- Carry chain: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0, cout=1, zero=1, ovf=0. Also a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, cout=0.
- Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0. Also a=b=0x1234_5678, sub=1 -> sum=0, zero=1, cout=1.
- Backpressure: stream 10 random beats back-to-back with out_ready low for cycles 4-9 -> in_ready drops after 3 beats are held; outputs stay stable while stalled; all 10 results match the reference model in order.
- Reset mid-flight: accept 3 beats, assert rst_n=0 for 1 cycle between clock edges -> out_valid=0 immediately; none of the 3 results appear after release; the next beat has 3-cycle latency.
- Parameter sweep REG_MASK=5'b00000 and 5'b11111 -> latencies 2 and 7; 10^5 random beats with random out_ready all match the golden a+b(+cin)/a-b model.

Source files
------------

// File: rtl/prefix_adder_pipe_if.sv
// Operand/result handshake bundle for the pipelined prefix adder.
// The master side drives operands and consumes results; the slave is the adder.
interface prefix_adder_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/prefix_adder_pipe.sv
// Pipelined 32-bit Kogge-Stone adder/subtractor with valid/ready on both sides.
// REG_MASK bit k inserts a pipeline register after the prefix level of span 1<<k.
module prefix_adder_pipe #(
  parameter logic [4:0] REG_MASK = 5'b00100,
  parameter int         WIDTH    = 32
) (
  input logic clk,
  input logic rst_n,
  prefix_adder_pipe_if.slave bus
);

  if (WIDTH != 32) begin : g_bad_width
    $error("prefix_adder_pipe: WIDTH must be 32");
  end

  typedef struct packed {
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] hp;
    logic        c0;
  } pfx_t;

  function automatic pfx_t combine(input pfx_t x, input int d);
    pfx_t        y;
    logic [31:0] low;
    low  = (32'h1 << d) - 32'h1;
    y    = x;
    y.g  = x.g | (x.p & (x.g << d));
    y.p  = x.p & ((x.p << d) | low);
    return y;
  endfunction

  logic [31:0] bb;
  logic        c0_in;
  pfx_t        gen;

  pfx_t        s0_q;
  logic        s0_v;
  pfx_t        lev_q  [1:5];
  logic        lev_v  [1:5];
  pfx_t        lvl_d  [1:5];
  logic        lvl_vd [1:5];
  logic        rdy    [0:5];
  logic        in_ready_int;

  logic [31:0] fin_g;
  logic [31:0] fin_hp;
  logic        fin_c0;
  logic        fin_v;

  logic [31:0] carry;
  logic [31:0] res_sum;
  logic        res_cout;
  logic        res_ovf;
  logic        res_zero;

  logic        out_valid_q;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;
  logic        zero_q;

  // Bit 0 folds the carry-in into its generate so the prefix tree needs no extra input.
  always_comb begin
    bb       = bus.sub ? ~bus.b : bus.b;
    c0_in    = bus.sub | bus.cin;
    gen.hp   = bus.a ^ bb;
    gen.p    = bus.a ^ bb;
    gen.g    = bus.a & bb;
    gen.g[0] = (bus.a[0] & bb[0]) | (gen.p[0] & c0_in);
    gen.c0   = c0_in;
  end

  // Walk the five prefix levels, switching to the register copy wherever one is inserted.
  always_comb begin
    pfx_t cur;
    logic cv;
    cur = s0_q;
    cv  = s0_v;
    for (int k = 1; k <= 5; k++) begin
      cur       = combine(cur, 1 << (k - 1));
      lvl_d[k]  = cur;
      lvl_vd[k] = cv;
      if (REG_MASK[k-1]) begin
        cur = lev_q[k];
        cv  = lev_v[k];
      end
    end
    fin_g  = cur.g;
    fin_hp = cur.hp;
    fin_c0 = cur.c0;
    fin_v  = cv;
  end

  // rdy[k]: the next registered stage downstream of level k can take a beat.
  always_comb begin
    logic r;
    r      = ~out_valid_q | bus.out_ready;
    rdy[5] = r;
    for (int k = 4; k >= 0; k--) begin
      if (REG_MASK[k]) begin
        r = ~lev_v[k+1] | r;
      end
      rdy[k] = r;
    end
  end

  assign in_ready_int = ~s0_v | rdy[0];

  always_comb begin
    carry    = {fin_g[30:0], fin_c0};
    res_sum  = fin_hp ^ carry;
    res_cout = fin_g[31];
    res_ovf  = carry[31] ^ fin_g[31];
    res_zero = (res_sum == 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v <= 1'b0;
      s0_q <= '0;
    end else if (in_ready_int) begin
      s0_v <= bus.in_valid;
      if (bus.in_valid) begin
        s0_q <= gen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= 5; k++) begin
        lev_v[k] <= 1'b0;
        lev_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= 5; k++) begin
        if (REG_MASK[k-1] && rdy[k-1]) begin
          lev_v[k] <= lvl_vd[k];
          if (lvl_vd[k]) begin
            lev_q[k] <= lvl_d[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= 32'h0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (rdy[5]) begin
      out_valid_q <= fin_v;
      if (fin_v) begin
        sum_q  <= res_sum;
        cout_q <= res_cout;
        ovf_q  <= res_ovf;
        zero_q <= res_zero;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed vector table on three REG_MASK builds,
// plus backpressure, mid-flight reset and random-ready streaming sequences.
module tb_prefix_adder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_valid [3];
  logic        s_ordy  [3];
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        s_cin;
  logic        s_sub;

  logic        o_irdy  [3];
  logic        o_valid [3];
  logic        o_cout  [3];
  logic        o_ovf   [3];
  logic        o_zero  [3];
  logic [31:0] o_sum   [3];

  int errors = 0;
  int checks = 0;

  // Instance 0 uses the default mask; 1 and 2 cover the shallowest and deepest pipes.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [4:0] MASK = (g == 0) ? 5'b00100 : ((g == 1) ? 5'b00000 : 5'b11111);
    prefix_adder_pipe_if bus ();
    assign bus.in_valid  = s_valid[g];
    assign bus.out_ready = s_ordy[g];
    assign bus.a         = s_a;
    assign bus.b         = s_b;
    assign bus.cin       = s_cin;
    assign bus.sub       = s_sub;
    assign o_irdy[g]     = bus.in_ready;
    assign o_valid[g]    = bus.out_valid;
    assign o_sum[g]      = bus.sum;
    assign o_cout[g]     = bus.cout;
    assign o_ovf[g]      = bus.ovf;
    assign o_zero[g]     = bus.zero;
    prefix_adder_pipe #(.REG_MASK(MASK), .WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [13];

  logic [31:0] st_a   [400];
  logic [31:0] st_b   [400];
  logic        st_cin [400];
  logic        st_sub [400];
  logic [31:0] ex_sum [400];
  logic [2:0]  ex_flg [400];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                input logic sub, output logic [31:0] sum, output logic [2:0] flg);
    logic [31:0] bb;
    logic [32:0] t;
    logic        ov;
    bb  = sub ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {32'h0, (sub ? 1'b1 : cin)};
    sum = t[31:0];
    ov  = (a[31] == bb[31]) && (sum[31] != a[31]);
    flg = {t[32], ov, (sum == 32'h0)};
  endfunction

  // One isolated beat: measure edges from accept to out_valid, then check the result.
  task automatic applyStimulus(input int d, input vec_t v, input int exp_lat, input string tag);
    int lat;
    s_a        = v.a;
    s_b        = v.b;
    s_cin      = v.cin;
    s_sub      = v.sub;
    s_ordy[d]  = 1'b1;
    s_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    s_valid[d] = 1'b0;
    lat = 1;
    while (!o_valid[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput($sformatf("%s latency", tag), lat, exp_lat);
    checkOutput($sformatf("%s sum", tag), o_sum[d], v.sum);
    checkOutput($sformatf("%s cout/ovf/zero", tag), {29'h0, o_cout[d], o_ovf[d], o_zero[d]},
                {29'h0, v.cout, v.ovf, v.zero});
    @(posedge clk);
    #1;
  endtask

  // Back-to-back source; sink either stalls on cycles 4..9 (pat) or is random.
  task automatic runStream(input int d, input int n, input bit pat, input string tag);
    int   sent, rcv, cyc, extra;
    bit   acc, prev_stall;
    logic [31:0] held_sum;
    logic [3:0]  held_flg;
    for (int i = 0; i < n; i++) begin
      st_a[i]   = $urandom;
      st_b[i]   = $urandom;
      st_cin[i] = 1'($urandom_range(0, 1));
      st_sub[i] = 1'($urandom_range(0, 1));
      model(st_a[i], st_b[i], st_cin[i], st_sub[i], ex_sum[i], ex_flg[i]);
    end
    sent = 0; rcv = 0; cyc = 0; prev_stall = 0;
    held_sum = 32'h0; held_flg = 4'h0;
    while (rcv < n && cyc < 30 * n + 100) begin
      s_ordy[d]  = pat ? !(cyc >= 4 && cyc <= 9) : ($urandom_range(0, 3) != 0);
      s_valid[d] = (sent < n);
      if (sent < n) begin
        s_a = st_a[sent]; s_b = st_b[sent]; s_cin = st_cin[sent]; s_sub = st_sub[sent];
      end
      #3;
      acc = s_valid[d] && o_irdy[d];
      if (pat && cyc <= 12) begin
        checkOutput($sformatf("%s in_ready c%0d", tag, cyc), {31'h0, o_irdy[d]},
                    {31'h0, !(cyc >= 4 && cyc <= 9)});
      end
      if (prev_stall) begin
        checkOutput($sformatf("%s hold sum c%0d", tag, cyc), o_sum[d], held_sum);
        checkOutput($sformatf("%s hold flags c%0d", tag, cyc),
                    {28'h0, o_valid[d], o_cout[d], o_ovf[d], o_zero[d]}, {28'h0, held_flg});
      end
      if (o_valid[d] && s_ordy[d] && rcv < n) begin
        checkOutput($sformatf("%s sum #%0d", tag, rcv), o_sum[d], ex_sum[rcv]);
        checkOutput($sformatf("%s flags #%0d", tag, rcv), {29'h0, o_cout[d], o_ovf[d], o_zero[d]},
                    {29'h0, ex_flg[rcv]});
        rcv++;
      end
      prev_stall = o_valid[d] && !s_ordy[d];
      held_sum   = o_sum[d];
      held_flg   = {o_valid[d], o_cout[d], o_ovf[d], o_zero[d]};
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    s_valid[d] = 1'b0;
    s_ordy[d]  = 1'b1;
    checkOutput($sformatf("%s results received", tag), rcv, n);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (o_valid[d]) extra++;
    end
    checkOutput($sformatf("%s extra outputs", tag), extra, 0);
  endtask

  initial begin
    int spurious;
    vecs[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) begin
      s_valid[d] = 1'b0;
      s_ordy[d]  = 1'b1;
    end
    s_a = 32'h0; s_b = 32'h0; s_cin = 1'b0; s_sub = 1'b0;

    #2;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset d%0d out_valid", d), {31'h0, o_valid[d]}, 32'h0);
      checkOutput($sformatf("reset d%0d in_ready", d), {31'h0, o_irdy[d]}, 32'h1);
      checkOutput($sformatf("reset d%0d sum", d), o_sum[d], 32'h0);
      checkOutput($sformatf("reset d%0d flags", d), {29'h0, o_cout[d], o_ovf[d], o_zero[d]}, 32'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) applyStimulus(0, vecs[i], 3, $sformatf("mask00100 v%0d", i));
    for (int i = 0; i < 13; i++) applyStimulus(1, vecs[i], 2, $sformatf("mask00000 v%0d", i));
    for (int i = 0; i < 13; i++) applyStimulus(2, vecs[i], 7, $sformatf("mask11111 v%0d", i));

    runStream(0, 10, 1'b1, "backpressure");

    // Three beats in flight, then a short reset pulse placed between clock edges.
    s_ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_a = vecs[i].a; s_b = vecs[i].b; s_cin = vecs[i].cin; s_sub = vecs[i].sub;
      s_valid[0] = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid[0] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", {31'h0, o_valid[0]}, 32'h0);
    checkOutput("midreset in_ready", {31'h0, o_irdy[0]}, 32'h1);
    checkOutput("midreset sum", o_sum[0], 32'h0);
    #3;
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (o_valid[0]) spurious++;
    end
    checkOutput("midreset spurious outputs", spurious, 0);
    applyStimulus(0, vecs[12], 3, "after reset");

    runStream(0, 200, 1'b0, "random d0");
    runStream(1, 300, 1'b0, "random d1");
    runStream(2, 300, 1'b0, "random d2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
